// File: rtl/clause_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : clause_count_sequencer
//  Purpose  : Snapshots a clause-satisfied vector on start, counts its ones
//             CHUNK_WIDTH bits per cycle, then reports the count, a running
//             best, an improvement flag, an all-satisfied flag and an
//             iteration budget to the search control FSM.
//  Ports    :
//    in_clk             clock, all logic on posedge
//    in_reset           synchronous active-high reset
//    in_start           request one evaluation (sampled in IDLE only)
//    in_clear_run       clear best / iteration / limit / improved (IDLE only)
//    in_clauses         clause-satisfied vector, 1 = satisfied
//    out_busy           high while scanning or reporting
//    out_done           one-cycle pulse, results valid
//    out_ones           ones in the last evaluated snapshot
//    out_best_ones      maximum out_ones since reset/clear
//    out_improved       last evaluation strictly beat the previous best
//    out_all_satisfied  last out_ones equals NUMBER_OF_CLAUSES
//    out_iteration      completed evaluations since reset/clear (saturating)
//    out_limit_reached  out_iteration equals MAX_ITERATIONS
//  Revision : 1.0 - initial release
// ============================================================================
module clause_count_sequencer #(
  parameter int NUMBER_OF_CLAUSES                 = 16,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX = 4,
  parameter int CHUNK_WIDTH                       = 4,
  parameter int MAX_ITERATIONS                    = 1024,
  parameter int ITERATION_WIDTH                   = 11
) (
  input  logic                                         in_clk,
  input  logic                                         in_reset,
  input  logic                                         in_start,
  input  logic                                         in_clear_run,
  input  logic [NUMBER_OF_CLAUSES-1:0]                 in_clauses,
  output logic                                         out_busy,
  output logic                                         out_done,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0]   out_ones,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0]   out_best_ones,
  output logic                                         out_improved,
  output logic                                         out_all_satisfied,
  output logic [ITERATION_WIDTH-1:0]                   out_iteration,
  output logic                                         out_limit_reached
);

  localparam int C_CNT_W      = MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX + 1;
  localparam int C_NUM_CHUNKS = (NUMBER_OF_CLAUSES + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int C_IDX_W      = (C_NUM_CHUNKS > 1) ? $clog2(C_NUM_CHUNKS) : 1;
  // The chunk table is sized to the full index range so any index value
  // selects a defined (zero) chunk.
  localparam int C_SLOTS      = 1 << C_IDX_W;
  localparam int C_PAD_W      = C_SLOTS * CHUNK_WIDTH;

  localparam logic [C_CNT_W-1:0]         C_ALL_ONES = C_CNT_W'(NUMBER_OF_CLAUSES);
  localparam logic [C_IDX_W-1:0]         C_LAST_IDX = C_IDX_W'(C_NUM_CHUNKS - 1);
  localparam logic [C_IDX_W-1:0]         C_IDX_ONE  = C_IDX_W'(1);
  localparam logic [ITERATION_WIDTH-1:0] C_MAX_ITER = ITERATION_WIDTH'(MAX_ITERATIONS);
  localparam logic [ITERATION_WIDTH-1:0] C_ITER_ONE = ITERATION_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                       state_q;
  logic [NUMBER_OF_CLAUSES-1:0] snap_q;
  logic [C_CNT_W-1:0]           acc_q;
  logic [C_IDX_W-1:0]           idx_q;
  logic                         busy_q;
  logic                         done_q;
  logic [C_CNT_W-1:0]           ones_q;
  logic [C_CNT_W-1:0]           best_q;
  logic                         improved_q;
  logic                         all_sat_q;
  logic [ITERATION_WIDTH-1:0]   iter_q;
  logic                         limit_q;

  // --------------------------------------------------------------------------
  // Chunk selection and popcount
  // --------------------------------------------------------------------------
  logic [C_PAD_W-1:0]     w_padded;
  logic [CHUNK_WIDTH-1:0] w_chunks [C_SLOTS];
  logic [CHUNK_WIDTH-1:0] w_chunk;
  logic [C_CNT_W-1:0]     w_chunk_ones;
  logic [C_CNT_W-1:0]     acc_d;
  logic [ITERATION_WIDTH-1:0] iter_d;

  // Bits beyond NUMBER_OF_CLAUSES are forced to zero so the last partial
  // chunk and unused slots contribute nothing.
  always_comb begin
    w_padded                          = '0;
    w_padded[NUMBER_OF_CLAUSES-1:0]   = snap_q;
  end

  for (genvar g = 0; g < C_SLOTS; g++) begin : g_chunk
    assign w_chunks[g] = w_padded[g*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  assign w_chunk = w_chunks[idx_q];

  always_comb begin
    w_chunk_ones = '0;
    for (int b = 0; b < CHUNK_WIDTH; b++) begin
      w_chunk_ones = w_chunk_ones + C_CNT_W'(w_chunk[b]);
    end
  end

  assign acc_d  = acc_q + w_chunk_ones;
  assign iter_d = (iter_q == C_MAX_ITER) ? iter_q : (iter_q + C_ITER_ONE);

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ones_q     <= '0;
      best_q     <= '0;
      improved_q <= 1'b0;
      all_sat_q  <= 1'b0;
      iter_q     <= '0;
      limit_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // Clear takes priority: a start in the same cycle is dropped.
          if (in_clear_run) begin
            best_q     <= '0;
            iter_q     <= '0;
            limit_q    <= 1'b0;
            improved_q <= 1'b0;
          end else if (in_start && !limit_q) begin
            snap_q  <= in_clauses;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          acc_q <= acc_d;
          idx_q <= idx_q + C_IDX_ONE;
          if (idx_q == C_LAST_IDX) begin
            state_q <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          ones_q     <= acc_q;
          all_sat_q  <= (acc_q == C_ALL_ONES);
          improved_q <= (acc_q > best_q);
          if (acc_q > best_q) begin
            best_q <= acc_q;
          end
          iter_q  <= iter_d;
          limit_q <= (iter_d == C_MAX_ITER);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_busy          = busy_q;
  assign out_done          = done_q;
  assign out_ones          = ones_q;
  assign out_best_ones     = best_q;
  assign out_improved      = improved_q;
  assign out_all_satisfied = all_sat_q;
  assign out_iteration     = iter_q;
  assign out_limit_reached = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_clause_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clause_count_sequencer
//  Purpose  : Directed self-checking bench for clause_count_sequencer.
//             Instance A: defaults (N=16, CW=4).  Instance B: MAX_ITERATIONS=3.
//             Instance C: N=10, CW=4 (three chunks, padded last chunk).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clause_count_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Instance A ----------------
  logic        a_rst = 1'b1, a_start = 1'b0, a_clr = 1'b0;
  logic [15:0] a_cl = '0;
  logic        a_busy, a_done, a_imp, a_all, a_lim;
  logic [4:0]  a_ones, a_best;
  logic [10:0] a_iter;

  clause_count_sequencer u_a (
    .in_clk(clk), .in_reset(a_rst), .in_start(a_start), .in_clear_run(a_clr),
    .in_clauses(a_cl), .out_busy(a_busy), .out_done(a_done), .out_ones(a_ones),
    .out_best_ones(a_best), .out_improved(a_imp), .out_all_satisfied(a_all),
    .out_iteration(a_iter), .out_limit_reached(a_lim)
  );

  // ---------------- Instance B ----------------
  logic        b_rst = 1'b1, b_start = 1'b0, b_clr = 1'b0;
  logic [15:0] b_cl = '0;
  logic        b_busy, b_done, b_imp, b_all, b_lim;
  logic [4:0]  b_ones, b_best;
  logic [10:0] b_iter;

  clause_count_sequencer #(.MAX_ITERATIONS(3)) u_b (
    .in_clk(clk), .in_reset(b_rst), .in_start(b_start), .in_clear_run(b_clr),
    .in_clauses(b_cl), .out_busy(b_busy), .out_done(b_done), .out_ones(b_ones),
    .out_best_ones(b_best), .out_improved(b_imp), .out_all_satisfied(b_all),
    .out_iteration(b_iter), .out_limit_reached(b_lim)
  );

  // ---------------- Instance C ----------------
  logic        c_rst = 1'b1, c_start = 1'b0, c_clr = 1'b0;
  logic [9:0]  c_cl = '0;
  logic        c_busy, c_done, c_imp, c_all, c_lim;
  logic [4:0]  c_ones, c_best;
  logic [10:0] c_iter;

  clause_count_sequencer #(.NUMBER_OF_CLAUSES(10)) u_c (
    .in_clk(clk), .in_reset(c_rst), .in_start(c_start), .in_clear_run(c_clr),
    .in_clauses(c_cl), .out_busy(c_busy), .out_done(c_done), .out_ones(c_ones),
    .out_best_ones(c_best), .out_improved(c_imp), .out_all_satisfied(c_all),
    .out_iteration(c_iter), .out_limit_reached(c_lim)
  );

  // Done-pulse counters
  int a_dn = 0, b_dn = 0;
  always @(negedge clk) if (a_done) a_dn++;
  always @(negedge clk) if (b_done) b_dn++;

  // One evaluation on instance A with full result check
  task automatic a_run(input string tag, input logic [15:0] v, input logic [4:0] e_ones,
                       input logic e_imp, input logic [4:0] e_best, input logic [10:0] e_iter,
                       input logic e_all);
    int  n;
    bit  seen;
    a_cl    = v;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = a_done;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, 5);
    check({tag, "_ones"}, a_ones, e_ones);
    check({tag, "_improved"}, a_imp, e_imp);
    check({tag, "_best"}, a_best, e_best);
    check({tag, "_iter"}, a_iter, e_iter);
    check({tag, "_all_sat"}, a_all, e_all);
    tick();
    check({tag, "_done_drops"}, a_done, 0);
  endtask

  task automatic b_eval(input string tag);
    int n;
    bit seen;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = b_done;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) tick();

    // ---- Reset state ----
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ones", a_ones, 0);
    check("rst_best", a_best, 0);
    check("rst_iter", a_iter, 0);
    check("rst_flags", {a_imp, a_all, a_lim}, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    c_rst = 1'b0;
    tick();

    // ---- All clauses satisfied ----
    a_cl    = 16'hFFFF;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("full_busy_scan", a_busy, 1);
    repeat (4) tick();
    check("full_no_done_edge4", a_done, 0);
    tick();
    check("full_done_edge5", a_done, 1);
    check("full_ones", a_ones, 16);
    check("full_all_sat", a_all, 1);
    check("full_improved", a_imp, 1);
    check("full_best", a_best, 16);
    check("full_iter", a_iter, 1);
    check("full_busy_idle", a_busy, 0);
    tick();
    check("full_done_pulse", a_done, 0);

    // ---- Clear run ----
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clr_best", a_best, 0);
    check("clr_iter", a_iter, 0);
    check("clr_improved", a_imp, 0);
    check("clr_ones_held", a_ones, 16);

    // ---- Sequence: 4, 8, 4, then equal 8 ----
    a_run("s1", 16'h00F0, 5'd4, 1'b1, 5'd4, 11'd1, 1'b0);
    a_run("s2", 16'h0FF0, 5'd8, 1'b1, 5'd8, 11'd2, 1'b0);
    a_run("s3", 16'h000F, 5'd4, 1'b0, 5'd8, 11'd3, 1'b0);
    a_run("s4eq", 16'h0FF0, 5'd8, 1'b0, 5'd8, 11'd4, 1'b0);

    // ---- Snapshot isolation: input/start/clear changes during SCAN ----
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    d0 = a_dn;
    a_cl    = 16'h0001;
    a_start = 1'b1;
    tick();                       // edge 0
    a_cl  = 16'hFFFF;
    a_clr = 1'b1;
    repeat (3) tick();            // edges 1..3
    a_start = 1'b0;
    a_clr   = 1'b0;
    tick();                       // edge 4
    tick();                       // edge 5 (REPORT)
    check("snap_done", a_done, 1);
    check("snap_ones", a_ones, 1);
    check("snap_iter", a_iter, 1);
    check("snap_best", a_best, 1);
    repeat (8) tick();
    check("snap_one_done", a_dn - d0, 1);
    check("snap_idle", a_busy, 0);

    // ---- Reset in the middle of a scan ----
    d0 = a_dn;
    a_cl    = 16'hFFFF;
    a_start = 1'b1;
    tick();                       // edge 0
    a_start = 1'b0;
    tick();                       // edge 1
    a_rst = 1'b1;
    tick();                       // edge 2 resets
    a_rst = 1'b0;
    check("mrst_busy", a_busy, 0);
    check("mrst_ones", a_ones, 0);
    check("mrst_best", a_best, 0);
    check("mrst_iter", a_iter, 0);
    check("mrst_flags", {a_done, a_imp, a_all, a_lim}, 0);
    repeat (8) tick();
    check("mrst_no_done", a_dn - d0, 0);
    a_run("post_rst", 16'h0F0F, 5'd8, 1'b1, 5'd8, 11'd1, 1'b0);

    // ---- Iteration limit (instance B, MAX_ITERATIONS=3) ----
    b_cl = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      b_eval("lim");
      check("lim_iter", b_iter, k + 1);
      check("lim_flag", b_lim, (k == 2) ? 1 : 0);
    end
    check("lim_ones", b_ones, 2);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("lim_start_ignored", b_busy, 0);
    repeat (8) tick();
    check("lim_done_count", b_dn, 3);
    check("lim_iter_hold", b_iter, 3);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    check("lim_clr_iter", b_iter, 0);
    check("lim_clr_flag", b_lim, 0);
    check("lim_clr_best", b_best, 0);
    b_eval("lim_after_clr");
    check("lim_after_clr_iter", b_iter, 1);

    // ---- Non-multiple width (instance C, N=10, three chunks) ----
    c_cl    = 10'h3FF;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    repeat (3) tick();
    check("n10_no_done_edge3", c_done, 0);
    tick();
    check("n10_done_edge4", c_done, 1);
    check("n10_ones", c_ones, 10);
    check("n10_all_sat", c_all, 1);
    tick();
    c_cl    = 10'h2AA;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    repeat (4) tick();
    check("n10b_done", c_done, 1);
    check("n10b_ones", c_ones, 5);
    check("n10b_all_sat", c_all, 0);
    check("n10b_best", c_best, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
